// File: rtl/unidade_controle_exp6_pkg.sv
`default_nettype none
// ============================================================================
// Module      : unidade_controle_exp6_pkg
// Description : State codes, strobe bundle and Moore output decode for the
//               memory-game controller.
// Revision    : 1.0 - initial release
// ============================================================================
package unidade_controle_exp6_pkg;

  localparam int STATE_W = 5;

  // Codes are visible on db_estado and feed the 7-segment debug decoder.
  typedef enum logic [STATE_W-1:0] {
    INICIAL        = 5'h00,
    PREPARACAO     = 5'h01,
    INICIALIZA_MEM = 5'h02,
    INICIO_RODADA  = 5'h03,
    MOSTRA_DADO    = 5'h04,
    PROXIMO_MOSTRA = 5'h05,
    FIM_MOSTRA     = 5'h06,
    ESPERA_JOGADA  = 5'h07,
    REGISTRA       = 5'h08,
    COMPARACAO     = 5'h09,
    PROXIMA_JOGADA = 5'h0A,
    ULTIMA_JOGADA  = 5'h0B,
    ESPERA_NOVA    = 5'h0C,
    ESCREVE_NOVA   = 5'h0D,
    PROXIMA_RODADA = 5'h0E,
    FIM_ACERTOU    = 5'h0F,
    FIM_ERROU      = 5'h10,
    FIM_TIMEOUT    = 5'h11
  } estado_t;

  typedef struct packed {
    logic zera_cl;
    logic conta_cl;
    logic zera_c;
    logic conta_c;
    logic escreve;
    logic zera_r;
    logic registra_r;
    logic espera_timeout;  // gated with the mode bit outside the register
    logic zera_timeout;
    logic conta_exibicao;
    logic zera_exibicao;
    logic registra_modo;
    logic reset_edge;
    logic seletor_leds;
    logic mostra_leds;
    logic botoes_fixo;
    logic pronto;
    logic ganhou;
    logic perdeu;
    logic timeout;
  } strobes_t;

  function automatic strobes_t decodifica(estado_t e);
    strobes_t s;
    s = '0;
    case (e)
      PREPARACAO: begin
        s.zera_cl       = 1'b1;
        s.zera_c        = 1'b1;
        s.zera_r        = 1'b1;
        s.zera_timeout  = 1'b1;
        s.zera_exibicao = 1'b1;
        s.registra_modo = 1'b1;
        s.reset_edge    = 1'b1;
      end
      INICIALIZA_MEM: begin
        s.escreve     = 1'b1;
        s.botoes_fixo = 1'b1;
      end
      INICIO_RODADA: begin
        s.zera_c        = 1'b1;
        s.zera_exibicao = 1'b1;
      end
      MOSTRA_DADO: begin
        s.mostra_leds    = 1'b1;
        s.seletor_leds   = 1'b1;
        s.conta_exibicao = 1'b1;
      end
      PROXIMO_MOSTRA: begin
        s.conta_c       = 1'b1;
        s.zera_exibicao = 1'b1;
      end
      FIM_MOSTRA: begin
        s.zera_c       = 1'b1;
        s.zera_timeout = 1'b1;
        s.zera_r       = 1'b1;
      end
      ESPERA_JOGADA, ESPERA_NOVA: begin
        s.mostra_leds    = 1'b1;
        s.espera_timeout = 1'b1;
      end
      REGISTRA: begin
        s.registra_r   = 1'b1;
        s.zera_timeout = 1'b1;
      end
      PROXIMA_JOGADA: s.conta_c = 1'b1;
      ULTIMA_JOGADA: begin
        s.conta_c      = 1'b1;
        s.zera_timeout = 1'b1;
      end
      ESCREVE_NOVA:   s.escreve  = 1'b1;
      PROXIMA_RODADA: s.conta_cl = 1'b1;
      FIM_ACERTOU: begin
        s.pronto = 1'b1;
        s.ganhou = 1'b1;
      end
      FIM_ERROU: begin
        s.pronto = 1'b1;
        s.perdeu = 1'b1;
      end
      FIM_TIMEOUT: begin
        s.pronto  = 1'b1;
        s.perdeu  = 1'b1;
        s.timeout = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/unidade_controle_exp6_if.sv
`default_nettype none
// ============================================================================
// Module      : unidade_controle_exp6_if
// Description : Controller <-> datapath bundle: status in, strobes out.
// Revision    : 1.0 - initial release
// ============================================================================
interface unidade_controle_exp6_if;
  import unidade_controle_exp6_pkg::*;

  logic iniciar;
  logic fimRodada;
  logic fimTotal;
  logic igual;
  logic jogada_feita;
  logic fimTimeout;
  logic fimExibicao;
  logic configTimeout_reg;

  logic zeraCL, contaCL, zeraC, contaC, escreve, zeraR, registraR;
  logic contaTimeout, zeraTimeout, contaExibicao, zeraExibicao;
  logic registraModo, resetEdgeDetector;
  logic seletorLedsBM, mostraLeds, botoes_fixo;
  logic pronto, ganhou, perdeu, timeout;
  logic [STATE_W-1:0] db_estado;

  // master: the controller; slave: the datapath / game top
  modport master (
    input  iniciar, fimRodada, fimTotal, igual, jogada_feita,
           fimTimeout, fimExibicao, configTimeout_reg,
    output zeraCL, contaCL, zeraC, contaC, escreve, zeraR, registraR,
           contaTimeout, zeraTimeout, contaExibicao, zeraExibicao,
           registraModo, resetEdgeDetector, seletorLedsBM, mostraLeds,
           botoes_fixo, pronto, ganhou, perdeu, timeout, db_estado
  );

  modport slave (
    output iniciar, fimRodada, fimTotal, igual, jogada_feita,
           fimTimeout, fimExibicao, configTimeout_reg,
    input  zeraCL, contaCL, zeraC, contaC, escreve, zeraR, registraR,
           contaTimeout, zeraTimeout, contaExibicao, zeraExibicao,
           registraModo, resetEdgeDetector, seletorLedsBM, mostraLeds,
           botoes_fixo, pronto, ganhou, perdeu, timeout, db_estado
  );

endinterface
`default_nettype wire

// File: rtl/unidade_controle_exp6.sv
`default_nettype none
// ============================================================================
// Module      : unidade_controle_exp6
// Description : Moore controller sequencing the memory-game datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module unidade_controle_exp6
  import unidade_controle_exp6_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  unidade_controle_exp6_if.master bus
);

  estado_t  state_q, state_d;
  strobes_t saidas_q, saidas_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL:        if (bus.iniciar) state_d = PREPARACAO;
      PREPARACAO:     state_d = INICIALIZA_MEM;
      INICIALIZA_MEM: state_d = INICIO_RODADA;
      INICIO_RODADA:  state_d = MOSTRA_DADO;
      MOSTRA_DADO:
        if (bus.fimExibicao) state_d = bus.fimRodada ? FIM_MOSTRA : PROXIMO_MOSTRA;
      PROXIMO_MOSTRA: state_d = MOSTRA_DADO;
      FIM_MOSTRA:     state_d = ESPERA_JOGADA;
      // A play arriving together with the timeout takes priority.
      ESPERA_JOGADA:
        if (bus.jogada_feita)                              state_d = REGISTRA;
        else if (bus.fimTimeout && bus.configTimeout_reg)  state_d = FIM_TIMEOUT;
      REGISTRA:       state_d = COMPARACAO;
      COMPARACAO:
        if (!bus.igual)         state_d = FIM_ERROU;
        else if (bus.fimRodada) state_d = bus.fimTotal ? FIM_ACERTOU : ULTIMA_JOGADA;
        else                    state_d = PROXIMA_JOGADA;
      PROXIMA_JOGADA: state_d = ESPERA_JOGADA;
      ULTIMA_JOGADA:  state_d = ESPERA_NOVA;
      ESPERA_NOVA:
        if (bus.jogada_feita)                              state_d = ESCREVE_NOVA;
        else if (bus.fimTimeout && bus.configTimeout_reg)  state_d = FIM_TIMEOUT;
      ESCREVE_NOVA:   state_d = PROXIMA_RODADA;
      PROXIMA_RODADA: state_d = INICIO_RODADA;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
        if (bus.iniciar) state_d = PREPARACAO;
      default:        state_d = INICIAL;
    endcase
    saidas_d = decodifica(state_d);
  end

  // Outputs are decoded from the next state so they flop in step with it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= INICIAL;
      saidas_q <= '0;
    end else begin
      state_q  <= state_d;
      saidas_q <= saidas_d;
    end
  end

  assign bus.zeraCL            = saidas_q.zera_cl;
  assign bus.contaCL           = saidas_q.conta_cl;
  assign bus.zeraC             = saidas_q.zera_c;
  assign bus.contaC            = saidas_q.conta_c;
  assign bus.escreve           = saidas_q.escreve;
  assign bus.zeraR             = saidas_q.zera_r;
  assign bus.registraR         = saidas_q.registra_r;
  assign bus.contaTimeout      = saidas_q.espera_timeout & bus.configTimeout_reg;
  assign bus.zeraTimeout       = saidas_q.zera_timeout;
  assign bus.contaExibicao     = saidas_q.conta_exibicao;
  assign bus.zeraExibicao      = saidas_q.zera_exibicao;
  assign bus.registraModo      = saidas_q.registra_modo;
  assign bus.resetEdgeDetector = saidas_q.reset_edge;
  assign bus.seletorLedsBM     = saidas_q.seletor_leds;
  assign bus.mostraLeds        = saidas_q.mostra_leds;
  assign bus.botoes_fixo       = saidas_q.botoes_fixo;
  assign bus.pronto            = saidas_q.pronto;
  assign bus.ganhou            = saidas_q.ganhou;
  assign bus.perdeu            = saidas_q.perdeu;
  assign bus.timeout           = saidas_q.timeout;
  assign bus.db_estado         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle_exp6.sv
`default_nettype none
// ============================================================================
// Module      : tb_unidade_controle_exp6
// Description : Scoreboard bench for the memory-game controller, with a
//               small emulated datapath and a rule-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_unidade_controle_exp6;

  localparam int DISP = 8;   // shortened display timer
  localparam int TOUT = 30;  // shortened play timeout

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  unidade_controle_exp6_if bus();
  unidade_controle_exp6 dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  typedef struct { int estado; logic [19:0] saidas; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [19:0] obs;
  assign obs = {bus.timeout, bus.perdeu, bus.ganhou, bus.pronto, bus.botoes_fixo,
                bus.mostraLeds, bus.seletorLedsBM, bus.resetEdgeDetector,
                bus.registraModo, bus.zeraExibicao, bus.contaExibicao,
                bus.zeraTimeout, bus.contaTimeout, bus.registraR, bus.zeraR,
                bus.escreve, bus.contaC, bus.zeraC, bus.contaCL, bus.zeraCL};

  // ---------------- reference model ----------------
  function automatic logic [31:0] S(int x);
    return 32'd1 << x;
  endfunction

  // Column view: for each output, the set of state codes asserting it.
  function automatic logic [31:0] set_of(int i);
    case (i)
      0:  return S(1);
      1:  return S(14);
      2:  return S(1) | S(3) | S(6);
      3:  return S(5) | S(10) | S(11);
      4:  return S(2) | S(13);
      5:  return S(1) | S(6);
      6:  return S(8);
      7:  return S(7) | S(12);
      8:  return S(1) | S(6) | S(8) | S(11);
      9:  return S(4);
      10: return S(1) | S(3) | S(5);
      11: return S(1);
      12: return S(1);
      13: return S(4);
      14: return S(4) | S(7) | S(12);
      15: return S(2);
      16: return S(15) | S(16) | S(17);
      17: return S(15);
      18: return S(16) | S(17);
      19: return S(17);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [19:0] ref_saidas(int e, logic cfg);
    logic [19:0] v;
    logic [31:0] m;
    for (int i = 0; i < 20; i++) begin
      m = set_of(i);
      v[i] = m[e];
    end
    v[7] = v[7] & cfg;
    return v;
  endfunction

  function automatic int ref_next(int e, logic ini, logic fr, logic ft, logic ig,
                                  logic jf, logic fto, logic fex, logic cfg);
    case (e)
      0:  return ini ? 1 : 0;
      1:  return 2;
      2:  return 3;
      3:  return 4;
      4:  return fex ? (fr ? 6 : 5) : 4;
      5:  return 4;
      6:  return 7;
      7:  return jf ? 8 : ((fto && cfg) ? 17 : 7);
      8:  return 9;
      9:  return !ig ? 16 : (fr ? (ft ? 15 : 11) : 10);
      10: return 7;
      11: return 12;
      12: return jf ? 13 : ((fto && cfg) ? 17 : 12);
      13: return 14;
      14: return 3;
      15, 16, 17: return ini ? 1 : e;
      default: return 0;
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      checks++;
      if (int'(bus.db_estado) != x.estado) begin
        errors++;
        $display("FAIL estado t=%0t got %0h expected %0h", $time, bus.db_estado, x.estado);
      end
      checks++;
      if (obs !== x.saidas) begin
        errors++;
        $display("FAIL saidas t=%0t state %0h got %05h expected %05h",
                 $time, bus.db_estado, obs, x.saidas);
      end
    end
  end

  // ---------------- emulated datapath / stimulus ----------------
  int   m_est = 0;
  bit   emulado = 1'b1;
  logic cfg_v = 1'b0;
  bit   press_en, force_to, err_en;
  int   err_r, err_c, lim;
  int   c, cl, tex, tto, wait_cnt, escritas;
  int   disp[16];

  task automatic drive_inputs();
    if (!emulado) begin
      bus.iniciar      = ($urandom_range(0, 7) == 0);
      bus.fimRodada    = ($urandom_range(0, 2) == 0);
      bus.fimTotal     = ($urandom_range(0, 2) == 0);
      bus.igual        = ($urandom_range(0, 3) != 0);
      bus.jogada_feita = ($urandom_range(0, 5) == 0);
      bus.fimTimeout   = ($urandom_range(0, 9) == 0);
      bus.fimExibicao  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) cfg_v = ~cfg_v;
      bus.configTimeout_reg = cfg_v;
      return;
    end
    bus.iniciar           = 1'b0;
    bus.configTimeout_reg = cfg_v;
    bus.fimRodada   = (c == cl);
    bus.fimTotal    = (cl == lim);
    bus.fimExibicao = (tex >= DISP);
    bus.fimTimeout  = force_to || (tto >= TOUT);
    bus.igual       = !(err_en && cl == err_r && c == err_c);
    bus.jogada_feita = 1'b0;
    if (bus.mostraLeds && !bus.seletorLedsBM && press_en) begin
      if (wait_cnt == 0) begin
        bus.jogada_feita = 1'b1;
        wait_cnt = $urandom_range(0, 5);
      end else wait_cnt--;
    end
    // register updates take effect at the coming edge
    if (bus.zeraC) c = 0; else if (bus.contaC) c++;
    if (bus.zeraCL) cl = 0; else if (bus.contaCL) cl++;
    if (bus.zeraExibicao) tex = 0; else if (bus.contaExibicao) tex++;
    if (bus.zeraTimeout) tto = 0; else if (bus.contaTimeout) tto++;
    if (bus.escreve) escritas++;
    if (bus.seletorLedsBM && cl < 16) disp[cl]++;
  endtask

  task automatic ciclo();
    @(posedge clock);
    if (!reset_n) m_est = 0;
    else m_est = ref_next(m_est, bus.iniciar, bus.fimRodada, bus.fimTotal, bus.igual,
                          bus.jogada_feita, bus.fimTimeout, bus.fimExibicao,
                          bus.configTimeout_reg);
    sb.push_back('{m_est, ref_saidas(m_est, bus.configTimeout_reg)});
    @(negedge clock);
    #1;
    drive_inputs();
  endtask

  task automatic reset_mid();
    @(posedge clock);
    #2 reset_n = 1'b0;
    m_est = 0;
    sb.push_back('{0, ref_saidas(0, bus.configTimeout_reg)});
    @(negedge clock);
    #1;
    drive_inputs();
  endtask

  task automatic check(string nome, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nome, got, want);
    end
  endtask

  task automatic start_game(logic cfg, bit press, bit err, int r, int e);
    cfg_v = cfg; press_en = press; err_en = err; err_r = r; err_c = e;
    force_to = 1'b0; lim = 3; escritas = 0; wait_cnt = 0;
    for (int i = 0; i < 16; i++) disp[i] = 0;
    bus.configTimeout_reg = cfg;
    bus.iniciar = 1'b1;
    ciclo();
  endtask

  task automatic run_until(string nome, int code, int budget);
    int n = 0;
    while (int'(bus.db_estado) != code && n < budget) begin
      ciclo();
      n++;
    end
    check(nome, int'(bus.db_estado), code);
  endtask

  initial begin
    bus.iniciar = 0; bus.fimRodada = 0; bus.fimTotal = 0; bus.igual = 0;
    bus.jogada_feita = 0; bus.fimTimeout = 0; bus.fimExibicao = 0;
    bus.configTimeout_reg = 0;
    c = 0; cl = 0; tex = 0; tto = 0; lim = 3;
    press_en = 0; force_to = 0; err_en = 0; err_r = 0; err_c = 0;
    escritas = 0; wait_cnt = 0;
    #1;
    repeat (3) ciclo();
    reset_n = 1'b1;
    repeat (3) ciclo();
    check("idle_estado", int'(bus.db_estado), 0);

    // winning game, mode 01: 4 rounds, no timeout
    start_game(1'b0, 1'b1, 1'b0, 0, 0);
    run_until("win_end", 15, 3000);
    check("win_ganhou", int'(bus.ganhou), 1);
    check("win_escritas", escritas, 4);
    check("win_disp_r3", disp[2], 3 * (DISP + 1));

    // wrong play in round 2, element 1
    start_game(1'b0, 1'b1, 1'b1, 1, 1);
    run_until("err_end", 16, 3000);
    check("err_timeout", int'(bus.timeout), 0);

    // timeout enabled, player idle
    start_game(1'b1, 1'b0, 1'b0, 0, 0);
    run_until("to_end", 17, 3000);
    check("to_flag", int'(bus.timeout), 1);

    // timeout disabled: forced timeout ignored
    start_game(1'b0, 1'b0, 1'b0, 0, 0);
    force_to = 1'b1;
    run_until("noto_wait", 7, 500);
    repeat (200) ciclo();
    check("noto_hold", int'(bus.db_estado), 7);

    // play and enabled timeout in the same cycle: play wins
    force_to = 1'b0;
    cfg_v = 1'b1;
    bus.configTimeout_reg = 1'b1;
    bus.jogada_feita = 1'b1;
    bus.fimTimeout = 1'b1;
    ciclo();
    check("simul", int'(bus.db_estado), 8);
    press_en = 1'b1;
    run_until("simul_end", 15, 3000);

    // reset during display
    start_game(1'b0, 1'b1, 1'b0, 0, 0);
    run_until("rst_wait", 4, 500);
    repeat (3) ciclo();
    reset_mid();
    ciclo();
    reset_n = 1'b1;
    repeat (2) ciclo();
    check("rst_estado", int'(bus.db_estado), 0);

    // unconstrained random inputs with occasional resets
    emulado = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_mid();
        ciclo();
        reset_n = 1'b1;
      end
      ciclo();
    end

    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
